// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared AES definitions used by the key schedule manager and the cipher round:
//   key-length encodings, Nk/Nr/Wtot lookups, the Rcon table, the S-box,
//   and the word helpers RotWord/SubWord.
package aes_pkg;

   localparam logic [1:0] KEY_LEN_INV = 2'b00;
   localparam logic [1:0] KEY_LEN_128 = 2'b01;
   localparam logic [1:0] KEY_LEN_192 = 2'b10;
   localparam logic [1:0] KEY_LEN_256 = 2'b11;

   localparam int MAX_ROUNDS = 15;  // round keys 0..14
   localparam int MAX_NK     = 8;   // sliding window depth in words

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_DONE
   } mgr_state_e;

   function automatic logic [3:0] nk_of(input logic [1:0] len);
      case (len)
         KEY_LEN_192: return 4'd6;
         KEY_LEN_256: return 4'd8;
         default:     return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] len);
      case (len)
         KEY_LEN_192: return 4'd12;
         KEY_LEN_256: return 4'd14;
         default:     return 4'd10;
      endcase
   endfunction

   // Total schedule words 4*(Nr+1).
   function automatic logic [5:0] wtot_of(input logic [1:0] len);
      case (len)
         KEY_LEN_192: return 6'd52;
         KEY_LEN_256: return 6'd60;
         default:     return 6'd44;
      endcase
   endfunction

   // Bits of the right-aligned key that take part in the tag compare.
   function automatic logic [255:0] key_mask(input logic [1:0] len);
      case (len)
         KEY_LEN_128: return {128'h0, {128{1'b1}}};
         KEY_LEN_192: return {64'h0, {192{1'b1}}};
         KEY_LEN_256: return {256{1'b1}};
         default:     return '0;
      endcase
   endfunction

   function automatic logic [7:0] rcon(input logic [5:0] j);
      case (j)
         6'd1:    return 8'h01;
         6'd2:    return 8'h02;
         6'd3:    return 8'h04;
         6'd4:    return 8'h08;
         6'd5:    return 8'h10;
         6'd6:    return 8'h20;
         6'd7:    return 8'h40;
         6'd8:    return 8'h80;
         6'd9:    return 8'h1b;
         6'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // S-box entry 0 sits in the most-significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_key_sched_mgr_if.sv
// aes_key_sched_mgr_if
//   Host/cipher-side bundle of the key schedule manager.
//   master: host side (drives key-load requests, flush and round-key read address)
//   slave : manager side (drives ready, completion, slot status and read data)
interface aes_key_sched_mgr_if
   import aes_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
);
   logic                 req_valid;
   logic                 req_ready;
   logic [SLOT_W-1:0]    req_slot;
   logic [255:0]         req_key;
   logic [1:0]           req_key_len;
   logic                 flush;
   logic                 done_valid;
   logic [SLOT_W-1:0]    done_slot;
   logic                 done_hit;
   logic                 done_err;
   logic [NUM_SLOTS-1:0] slot_ready;
   logic [SLOT_W-1:0]    rk_rd_slot;
   logic [3:0]           rk_rd_round;
   logic [127:0]         rk_rd_data;

   modport master (
      output req_valid, req_slot, req_key, req_key_len, flush, rk_rd_slot, rk_rd_round,
      input  req_ready, done_valid, done_slot, done_hit, done_err, slot_ready, rk_rd_data
   );

   modport slave (
      input  req_valid, req_slot, req_key, req_key_len, flush, rk_rd_slot, rk_rd_round,
      output req_ready, done_valid, done_slot, done_hit, done_err, slot_ready, rk_rd_data
   );
endinterface

// File: rtl/aes_key_word_gen.sv
// aes_key_word_gen
//   Combinational FIPS-197 key expansion step for word i >= Nk.
//   w_prev : w[i-1]
//   w_nk   : w[i-Nk]
//   idx    : word index i
//   nk     : key length in words (4, 6 or 8)
//   w_out  : w[i]
module aes_key_word_gen
   import aes_pkg::*;
(
   input  logic [31:0] w_prev,
   input  logic [31:0] w_nk,
   input  logic [5:0]  idx,
   input  logic [3:0]  nk,
   output logic [31:0] w_out
);
   logic [5:0]  nk6;
   logic [5:0]  imod;
   logic [5:0]  rnd;
   logic [31:0] temp;

   assign nk6  = {2'b00, nk};
   assign imod = idx % nk6;
   assign rnd  = idx / nk6;

   always_comb begin
      // NOTE: temp gets a value before any branch so no path leaves it unassigned (no latch).
      temp = w_prev;
      if (imod == 6'd0)
         temp = sub_word(rot_word(w_prev)) ^ {rcon(rnd), 24'h0};
      else if (nk == 4'd8 && imod == 6'd4)
         temp = sub_word(w_prev);
      w_out = w_nk ^ temp;
   end
endmodule

// File: rtl/aes_key_sched_mgr.sv
// aes_key_sched_mgr
//   Multi-slot AES key schedule manager. Accepts one key-load request at a time,
//   skips expansion when the slot already holds the same key/length, otherwise
//   expands one 32-bit word per cycle and stores the round keys per slot.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : request/completion handshake, flush, slot status and
//                  registered round-key read port (slave side)
module aes_key_sched_mgr
   import aes_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)(
   input  logic              clk,
   input  logic              reset_n,
   aes_key_sched_mgr_if.slave bus
);
   mgr_state_e state, state_nxt;

   logic [SLOT_W-1:0]    cur_slot;
   logic [1:0]           cur_len;
   logic                 cur_hit;
   logic                 cur_err;
   logic [5:0]           word_idx;
   logic [255:0]         key_sh;     // remaining key words, next one in [255:224]
   logic [31:0]          win [MAX_NK]; // win[k] = w[i-1-k]
   logic [95:0]          pack;       // first three words of the round key being built
   logic [NUM_SLOTS-1:0] slot_ready;
   logic [127:0]         rd_data;

   logic [255:0] tag_key [NUM_SLOTS];
   logic [1:0]   tag_len [NUM_SLOTS];
   logic [127:0] rk_mem  [NUM_SLOTS][MAX_ROUNDS];

   logic         idle_ok, accept, req_slot_ok, req_err, req_hit, miss_accept;
   logic [3:0]   cur_nk;
   logic [31:0]  w_gen, w_cur;
   logic         last_word, pack_wr;

   // Ready is also gated by reset so every output reads 0 while reset is held.
   assign idle_ok     = reset_n && state == ST_IDLE && !bus.flush;
   assign accept      = bus.req_valid && idle_ok;
   assign req_slot_ok = 32'(bus.req_slot) < NUM_SLOTS;
   assign req_err     = bus.req_key_len == KEY_LEN_INV || !req_slot_ok;
   assign req_hit     = !req_err && slot_ready[bus.req_slot]
                        && tag_len[bus.req_slot] == bus.req_key_len
                        && ((tag_key[bus.req_slot] ^ bus.req_key) & key_mask(bus.req_key_len)) == '0;
   assign miss_accept = accept && !req_err && !req_hit;

   assign cur_nk    = nk_of(cur_len);
   assign w_cur     = (word_idx < {2'b00, cur_nk}) ? key_sh[255:224] : w_gen;
   assign last_word = word_idx == wtot_of(cur_len) - 6'd1;
   assign pack_wr   = state == ST_EXPAND && word_idx[1:0] == 2'b11 && !bus.flush;

   aes_key_word_gen u_word_gen (
      .w_prev (win[0]),
      .w_nk   (win[3'(cur_nk - 4'd1)]),
      .idx    (word_idx),
      .nk     (cur_nk),
      .w_out  (w_gen)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.done_valid = 1'b0;
      bus.done_slot  = '0;
      bus.done_hit   = 1'b0;
      bus.done_err   = 1'b0;
      case (state)
         ST_IDLE:   if (accept) state_nxt = (req_err || req_hit) ? ST_DONE : ST_EXPAND;
         ST_EXPAND: if (last_word) state_nxt = ST_DONE;
         ST_DONE: begin
            state_nxt      = ST_IDLE;
            bus.done_valid = 1'b1;
            bus.done_slot  = cur_slot;
            bus.done_hit   = cur_hit;
            bus.done_err   = cur_err;
         end
         default:   state_nxt = ST_IDLE;
      endcase
      if (bus.flush) state_nxt = ST_IDLE;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_ready <= '0;
         cur_slot   <= '0;
         cur_len    <= '0;
         cur_hit    <= 1'b0;
         cur_err    <= 1'b0;
         word_idx   <= '0;
         key_sh     <= '0;
         pack       <= '0;
         rd_data    <= '0;
         for (int j = 0; j < MAX_NK; j++) win[j] <= '0;
      end else begin
         if (bus.flush)
            slot_ready <= '0;
         else if (miss_accept)
            slot_ready[bus.req_slot] <= 1'b0;
         else if (state == ST_EXPAND && last_word)
            slot_ready[cur_slot] <= 1'b1;

         if (accept) begin
            cur_slot <= bus.req_slot;
            cur_len  <= bus.req_key_len;
            cur_hit  <= req_hit;
            cur_err  <= req_err;
            word_idx <= '0;
            // Left-align the used key bits so w[0] is always key_sh[255:224].
            case (bus.req_key_len)
               KEY_LEN_128: key_sh <= {bus.req_key[127:0], 128'h0};
               KEY_LEN_192: key_sh <= {bus.req_key[191:0], 64'h0};
               default:     key_sh <= bus.req_key;
            endcase
         end else if (state == ST_EXPAND) begin
            word_idx <= word_idx + 6'd1;
            key_sh   <= {key_sh[223:0], 32'h0};
            pack     <= {pack[63:0], w_cur};
            win[0]   <= w_cur;
            for (int j = 1; j < MAX_NK; j++) win[j] <= win[j-1];
         end

         if (32'(bus.rk_rd_slot) < NUM_SLOTS && bus.rk_rd_round < 4'd15)
            rd_data <= rk_mem[bus.rk_rd_slot][bus.rk_rd_round];
      end
   end

   // ---------------- tags and round-key storage ----------------
   // NOTE: storage arrays carry no reset; slot_ready alone decides whether contents are valid.
   always_ff @(posedge clk) begin
      if (miss_accept) begin
         tag_key[bus.req_slot] <= bus.req_key;
         tag_len[bus.req_slot] <= bus.req_key_len;
      end
      if (pack_wr)
         rk_mem[cur_slot][word_idx[5:2]] <= {pack, w_cur};
   end

   assign bus.req_ready  = idle_ok;
   assign bus.slot_ready = slot_ready;
   assign bus.rk_rd_data = rd_data;

endmodule

// File: tb/tb_aes_key_sched_mgr.sv
module tb_aes_key_sched_mgr;
   import aes_pkg::*;

   localparam int NS = 4;
   localparam int SW = 2;

   localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R192_12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
   localparam logic [127:0] R256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   aes_key_sched_mgr_if #(.NUM_SLOTS(NS), .SLOT_W(SW)) bus ();

   aes_key_sched_mgr #(.NUM_SLOTS(NS), .SLOT_W(SW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Issue one request; report completion cycle (-1 on timeout) and status.
   task automatic do_req(input logic [SW-1:0] slot, input logic [255:0] key, input logic [1:0] len,
                         output int cyc, output logic hit, output logic err, output logic [SW-1:0] dslot,
                         output logic [NS-1:0] rdy_c1, output logic [NS-1:0] rdy_done,
                         output logic ready_after);
      @(negedge clk);
      bus.req_slot = slot; bus.req_key = key; bus.req_key_len = len; bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      cyc = -1; hit = 1'b0; err = 1'b0; dslot = '0; rdy_c1 = '0; rdy_done = '0; ready_after = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 1) rdy_c1 = bus.slot_ready;
         if (bus.done_valid) begin
            cyc = n; hit = bus.done_hit; err = bus.done_err; dslot = bus.done_slot;
            rdy_done = bus.slot_ready;
            @(negedge clk);
            ready_after = bus.req_ready;
            break;
         end
      end
   endtask

   task automatic rd(input logic [SW-1:0] slot, input logic [3:0] round, output logic [127:0] data);
      @(negedge clk);
      bus.rk_rd_slot = slot; bus.rk_rd_round = round;
      @(negedge clk);
      data = bus.rk_rd_data;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_slot = '0; bus.req_key = '0; bus.req_key_len = '0;
      bus.flush = 1'b0; bus.rk_rd_slot = '0; bus.rk_rd_round = '0;
      #23;
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
      n_cmp++; if (bus.done_valid !== 1'b0) begin n_bad++; $display("FAIL rst_done_valid: got %b expected 0", bus.done_valid); end
      n_cmp++; if (bus.slot_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_slot_ready: got %b expected 0000", bus.slot_ready); end
      n_cmp++; if (bus.rk_rd_data !== 128'h0) begin n_bad++; $display("FAIL rst_rd_data: got %h expected 0", bus.rk_rd_data); end
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b expected 1", bus.req_ready); end
   endtask

   task automatic test_expand(input logic [SW-1:0] slot, input logic [255:0] key, input logic [1:0] len,
                              input int exp_cyc, input logic [3:0] last_r, input logic [127:0] exp_last,
                              input logic [127:0] exp_r0);
      int cyc; logic hit, err, ra; logic [SW-1:0] ds; logic [NS-1:0] r1, rd_; logic [127:0] d;
      do_req(slot, key, len, cyc, hit, err, ds, r1, rd_, ra);
      n_cmp++; if (cyc !== exp_cyc) begin n_bad++; $display("FAIL exp_latency s%0d: got %0d expected %0d", slot, cyc, exp_cyc); end
      n_cmp++; if (hit !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL exp_flags s%0d: got hit=%b err=%b expected 0/0", slot, hit, err); end
      n_cmp++; if (ds !== slot) begin n_bad++; $display("FAIL exp_done_slot: got %0d expected %0d", ds, slot); end
      n_cmp++; if (r1[slot] !== 1'b0) begin n_bad++; $display("FAIL exp_ready_cleared s%0d: got %b expected 0", slot, r1[slot]); end
      n_cmp++; if (rd_[slot] !== 1'b1) begin n_bad++; $display("FAIL exp_ready_set s%0d: got %b expected 1", slot, rd_[slot]); end
      n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL exp_req_ready_back s%0d: got %b expected 1", slot, ra); end
      rd(slot, last_r, d);
      n_cmp++; if (d !== exp_last) begin n_bad++; $display("FAIL exp_round%0d s%0d: got %h expected %h", last_r, slot, d, exp_last); end
      rd(slot, 4'd0, d);
      n_cmp++; if (d !== exp_r0) begin n_bad++; $display("FAIL exp_round0 s%0d: got %h expected %h", slot, d, exp_r0); end
   endtask

   task automatic test_cross_slots();
      logic [127:0] d;
      rd(2'd0, 4'd1, d);
      n_cmp++; if (d !== R128_1) begin n_bad++; $display("FAIL cross_s0_r1: got %h expected %h", d, R128_1); end
      rd(2'd0, 4'd10, d);
      n_cmp++; if (d !== R128_10) begin n_bad++; $display("FAIL cross_s0_r10: got %h expected %h", d, R128_10); end
      rd(2'd1, 4'd12, d);
      n_cmp++; if (d !== R192_12) begin n_bad++; $display("FAIL cross_s1_r12: got %h expected %h", d, R192_12); end
      rd(2'd2, 4'd1, d);
      n_cmp++; if (d !== 128'h101112131415161718191a1b1c1d1e1f) begin n_bad++; $display("FAIL cross_s2_r1: got %h", d); end
   endtask

   task automatic test_hit();
      int cyc; logic hit, err, ra; logic [SW-1:0] ds; logic [NS-1:0] r1, rd_;
      do_req(2'd0, K128, KEY_LEN_128, cyc, hit, err, ds, r1, rd_, ra);
      n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL hit_latency: got %0d expected 1", cyc); end
      n_cmp++; if (hit !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL hit_flags: got hit=%b err=%b expected 1/0", hit, err); end
      n_cmp++; if (rd_ !== 4'b0111) begin n_bad++; $display("FAIL hit_slot_ready: got %b expected 0111", rd_); end
      n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL hit_ready_cycle2: got %b expected 1", ra); end
      // Upper 128 bits are not part of a 128-bit key.
      do_req(2'd0, {128'hdeadbeef_cafef00d_01234567_89abcdef, K128[127:0]}, KEY_LEN_128, cyc, hit, err, ds, r1, rd_, ra);
      n_cmp++; if (cyc !== 1 || hit !== 1'b1) begin n_bad++; $display("FAIL hit_upper_ignored: got cyc=%0d hit=%b expected 1/1", cyc, hit); end
   endtask

   task automatic test_len_change();
      int cyc; logic hit, err, ra; logic [SW-1:0] ds; logic [NS-1:0] r1, rd_; logic [127:0] d;
      do_req(2'd0, K128, KEY_LEN_256, cyc, hit, err, ds, r1, rd_, ra);
      n_cmp++; if (cyc !== 61 || hit !== 1'b0) begin n_bad++; $display("FAIL len_change_miss: got cyc=%0d hit=%b expected 61/0", cyc, hit); end
      rd(2'd0, 4'd1, d);
      n_cmp++; if (d !== K128[127:0]) begin n_bad++; $display("FAIL len_change_r1: got %h expected %h", d, K128[127:0]); end
   endtask

   task automatic test_err();
      int cyc; logic hit, err, ra; logic [SW-1:0] ds; logic [NS-1:0] r1, rd_;
      do_req(2'd1, K192, KEY_LEN_INV, cyc, hit, err, ds, r1, rd_, ra);
      n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL err_latency: got %0d expected 1", cyc); end
      n_cmp++; if (err !== 1'b1 || hit !== 1'b0) begin n_bad++; $display("FAIL err_flags: got err=%b hit=%b expected 1/0", err, hit); end
      n_cmp++; if (ds !== 2'd1) begin n_bad++; $display("FAIL err_done_slot: got %0d expected 1", ds); end
      n_cmp++; if (rd_ !== 4'b0111) begin n_bad++; $display("FAIL err_slot_ready: got %b expected 0111", rd_); end
   endtask

   task automatic test_flush();
      int dones = 0;
      @(negedge clk);
      bus.req_slot = 2'd3; bus.req_key = K128; bus.req_key_len = KEY_LEN_128; bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++; if (bus.slot_ready !== 4'b0111) begin n_bad++; $display("FAIL flush_pre_ready: got %b expected 0111", bus.slot_ready); end
      bus.flush = 1'b1;
      bus.req_slot = 2'd1; bus.req_key_len = KEY_LEN_INV; bus.req_valid = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_req_ready: got %b expected 0", bus.req_ready); end
      @(posedge clk);
      #1 bus.flush = 1'b0; bus.req_valid = 1'b0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (bus.done_valid) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL flush_no_done: got %0d expected 0", dones); end
      n_cmp++; if (bus.slot_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_slot_ready: got %b expected 0000", bus.slot_ready); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle: got %b expected 1", bus.req_ready); end
   endtask

   task automatic test_reset_mid();
      int cyc; logic hit, err, ra; logic [SW-1:0] ds; logic [NS-1:0] r1, rd_; logic [127:0] d;
      do_req(2'd1, K192, KEY_LEN_192, cyc, hit, err, ds, r1, rd_, ra);
      rd(2'd1, 4'd12, d);
      @(negedge clk);
      bus.req_slot = 2'd2; bus.req_key = K256; bus.req_key_len = KEY_LEN_256; bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (bus.slot_ready !== 4'b0000) begin n_bad++; $display("FAIL rmid_slot_ready: got %b expected 0000", bus.slot_ready); end
      n_cmp++; if (bus.rk_rd_data !== 128'h0) begin n_bad++; $display("FAIL rmid_rd_data: got %h expected 0", bus.rk_rd_data); end
      n_cmp++; if ({bus.req_ready, bus.done_valid, bus.done_hit, bus.done_err} !== 4'b0000) begin
         n_bad++; $display("FAIL rmid_ctrl: got %b expected 0000", {bus.req_ready, bus.done_valid, bus.done_hit, bus.done_err}); end
      @(negedge clk) reset_n = 1'b1;
      do_req(2'd0, K128, KEY_LEN_128, cyc, hit, err, ds, r1, rd_, ra);
      n_cmp++; if (cyc !== 45 || hit !== 1'b0) begin n_bad++; $display("FAIL rmid_reexpand: got cyc=%0d hit=%b expected 45/0", cyc, hit); end
      rd(2'd0, 4'd10, d);
      n_cmp++; if (d !== R128_10) begin n_bad++; $display("FAIL rmid_r10: got %h expected %h", d, R128_10); end
   endtask

   initial begin
      test_reset();
      test_expand(2'd0, K128, KEY_LEN_128, 45, 4'd10, R128_10, K128[127:0]);
      test_expand(2'd1, K192, KEY_LEN_192, 53, 4'd12, R192_12, 128'h000102030405060708090a0b0c0d0e0f);
      test_expand(2'd2, K256, KEY_LEN_256, 61, 4'd14, R256_14, 128'h000102030405060708090a0b0c0d0e0f);
      test_cross_slots();
      test_hit();
      test_err();
      test_flush();
      test_len_change();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
